multi_draw_sequencer: RTL
=========================

// Module: multi_draw_sequencer
// PURPOSE
//  Parametrised frame-draw sequencer for the game view: redraws splash, background, NUM_CLASSES
//  object classes (gold/stone/diamond/...), 1..NUM_HOOKS hooks and the HUD numbers once per frame.
//  It talks to the drawer mux over a single req/done handshake. It owns the per-class object
//  counters, frame pacing, level-up/game-over flow and overrun detection.
// PARAMETERS
//  NUM_CLASSES  3       object classes drawn each frame, class 0 first
//  NUM_HOOKS    2       maximum hook channels
//  CNT_W        5       width of per-class object count/index
//  FRAME_DIV    833333  clk cycles per frame tick (60 Hz at 50 MHz), >= 2
// PORTS
//  clk          in   1                      clock
//  resetn       in   1                      synchronous, active-low reset
//  go           in   1                      player start/continue key, level-sensitive
//  game_end     in   1                      round finished (timer or target)
//  next_level   in   1                      qualifies game_end: 1 = level passed, 0 = game over
//  hooks_active in   $clog2(NUM_HOOKS+1)    hooks drawn this frame; 0 is treated as 1, >NUM_HOOKS clamps
//  max_count    in   NUM_CLASSES*CNT_W      objects per class, class c at [c*CNT_W +: CNT_W]
//  draw_done    in   1                      drawer finished current request
//  draw_req     out  1                      drawer request
//  draw_kind    out  3                      SPLASH/BG/OBJ/HOOK/NUM/OVER/NEXT
//  draw_cls     out  $clog2(NUM_CLASSES)    class (OBJ) or hook number (HOOK), else 0
//  draw_idx     out  CNT_W                  object index within class (OBJ), else 0
//  enable_random out 1                      object position generator enable
//  timer_enable out  1                      game timer run
//  time_resetn  out  1                      game timer clear, active-low
//  rope_resetn  out  1                      rope/hook clear, active-low
//  obj_resetn   out  1                      caught-object state clear, active-low
//  level_up     out  1                      one-cycle level increment
//  level_resetn out  1                      level clear, active-low
//  overrun_cnt  out  8                      frames whose tick arrived before the redraw finished; saturates at 255
// BEHAVIOUR
//  Reset: state START, counters 0, overrun_cnt 0; all req/enable/level_up outputs 0; all *_resetn outputs 1.
//  FSM: START -> SPLASH (req, kind SPLASH, rope_resetn 0) until done -> ARM.
//   ARM: enable_random 1, time_resetn 0, rope_resetn 0; go -> BG.
//   BG -> OBJ.
//   OBJ: walks class c = 0..NUM_CLASSES-1, idx 0..max_count[c]-1; classes with max 0 are skipped
//    with no cycle spent. After the last object -> HOOK.
//   HOOK: h = 0..eff_hooks-1 -> NUM -> GAME.
//   GAME: obj_resetn 0.
//    game_end & next_level  -> NEXT.
//    game_end & !next_level -> OVER.
//    else frame tick or pending tick -> BG.
//    game_end has priority over a tick in the same cycle.
//   OVER (req) until done -> DONE_OVER: time/obj/rope/level_resetn 0; go -> WAIT_REL; !go -> SPLASH.
//   NEXT (req) until done -> DONE_NEXT: time/obj/rope_resetn 0; go -> LEVEL_UP (level_up=1, 1 cycle) -> BG.
//  Handshake:
//   - draw_req is 1 in every draw state; kind/cls/idx are stable while req is 1.
//   - draw_done is sampled only while req is 1. On done the FSM advances next edge and
//     the counters update in that same edge.
//   - Consecutive draws may keep req high; the kind/cls/idx change marks a new request.
//  timer_enable = 1 in BG/OBJ/HOOK/NUM/GAME.
//  Frame tick:
//   - Free-running divider, one-cycle pulse every FRAME_DIV clk; cleared by reset only.
//   - A tick outside GAME while drawing (BG..NUM) sets pending and increments overrun_cnt (saturating).
//   - GAME with pending set goes to BG next cycle and clears pending.
//   - Multiple ticks during one redraw count individually but leave a single pending.
//  max_count/hooks_active are sampled on entry to BG and held for that frame.
//  resetn low in any state aborts the request in the same edge. The drawer must tolerate req dropping.
// STRUCTURE
//  Package gm_view_pkg: draw_kind codes (SPLASH=0, BG=1, OBJ=2, HOOK=3, NUM=4, OVER=5, NEXT=6),
//  state encoding, FRAME_DIV default.
//  Sub-module frame_tick (FRAME_DIV divider, tick pulse). Everything else is in this module.
// TESTING
//  1 Reset, max_count={2,0,3} (c0=3,c1=0,c2=2), hooks_active=1, go pulse, done 1-cycle after each req
//    -> kind sequence BG, OBJ(0,0..2), OBJ(2,0..1), HOOK(0), NUM, then GAME; class 1 never requested.
//  2 hooks_active=2 vs 0 vs 3 (NUM_HOOKS=2) -> HOOK requests for h=0,1 / h=0 / h=0,1.
//  3 FRAME_DIV=64, draw_done delayed 100 cycles -> overrun_cnt increments, GAME lasts 1 cycle
//    before BG; hold to 255, verify saturation.
//  4 game_end=1,next_level=1 in same cycle as a frame tick
//    -> NEXT (not BG); after done+go: exactly one level_up cycle, then BG.
//  5 game_end=1,next_level=0 -> OVER, DONE_OVER asserts level_resetn=0; go held then released -> SPLASH.
//  6 resetn low mid-OBJ with req high -> next cycle all outputs at reset values, state START.

Source files
------------

// File: rtl/gm_view_pkg.sv
// Shared types for the game-view draw sequencer: drawer request kinds,
// sequencer state encoding, frame pacing default and small helpers.
package gm_view_pkg;

  // Request kinds understood by the drawer mux.
  typedef enum logic [2:0] {
    KIND_SPLASH = 3'd0,
    KIND_BG     = 3'd1,
    KIND_OBJ    = 3'd2,
    KIND_HOOK   = 3'd3,
    KIND_NUM    = 3'd4,
    KIND_OVER   = 3'd5,
    KIND_NEXT   = 3'd6
  } draw_kind_e;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_SPLASH    = 4'd1,
    ST_ARM       = 4'd2,
    ST_BG        = 4'd3,
    ST_OBJ       = 4'd4,
    ST_HOOK      = 4'd5,
    ST_NUM       = 4'd6,
    ST_GAME      = 4'd7,
    ST_OVER      = 4'd8,
    ST_DONE_OVER = 4'd9,
    ST_NEXT      = 4'd10,
    ST_DONE_NEXT = 4'd11,
    ST_LEVEL_UP  = 4'd12,
    ST_WAIT_REL  = 4'd13
  } state_e;

  // 60 Hz frame tick from a 50 MHz clock.
  localparam int unsigned FRAME_DIV_DEFAULT = 833333;

  localparam int unsigned OVERRUN_W = 8;

  // True while the per-frame redraw (BG..NUM) is in progress.
  function automatic logic is_frame_draw(input state_e s);
    return (s == ST_BG) || (s == ST_OBJ) || (s == ST_HOOK) || (s == ST_NUM);
  endfunction

  // Saturating increment for the overrun counter.
  function automatic logic [OVERRUN_W-1:0] sat_inc(input logic [OVERRUN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/multi_draw_sequencer_frame_tick.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks.
// Only reset restarts the phase; the sequencer never touches it.
module frame_tick
  import gm_view_pkg::*;
#(
  parameter int unsigned FRAME_DIV = FRAME_DIV_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // Count 0..FRAME_DIV-1 and wrap; the tick is the last count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!resetn) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multi_draw_sequencer.sv
// Frame-draw sequencer for the game view. Issues one drawer request at a
// time (splash, background, every object of every class, hooks, HUD numbers),
// paces frames from frame_tick, runs the level-up / game-over flow and counts
// frames whose tick arrived before the redraw finished.
module multi_draw_sequencer
  import gm_view_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned NUM_HOOKS   = 2,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned FRAME_DIV   = FRAME_DIV_DEFAULT,
  localparam int unsigned CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned HK_W       = $clog2(NUM_HOOKS + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         go,
  input  logic                         game_end,
  input  logic                         next_level,
  input  logic [HK_W-1:0]              hooks_active,
  input  logic [NUM_CLASSES*CNT_W-1:0] max_count,
  input  logic                         draw_done,
  output logic                         draw_req,
  output logic [2:0]                   draw_kind,
  output logic [CLS_W-1:0]             draw_cls,
  output logic [CNT_W-1:0]             draw_idx,
  output logic                         enable_random,
  output logic                         timer_enable,
  output logic                         time_resetn,
  output logic                         rope_resetn,
  output logic                         obj_resetn,
  output logic                         level_up,
  output logic                         level_resetn,
  output logic [7:0]                   overrun_cnt
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                         state_q, state_d;
  logic [CLS_W-1:0]               cls_q, cls_d;
  logic [CNT_W-1:0]               idx_q, idx_d;
  logic [HK_W-1:0]                hook_q, hook_d;
  logic [NUM_CLASSES*CNT_W-1:0]   max_q, max_d;     // counts frozen for this frame
  logic [HK_W-1:0]                hooks_q, hooks_d; // effective hooks for this frame
  logic                           pending_q, pending_d;
  logic [OVERRUN_W-1:0]           overrun_q, overrun_d;

  logic                           tick_w;
  draw_kind_e                     kind_c;

  frame_tick #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick_o (tick_w)
  );

  // ---------------------------------------------------------------------------
  // Frame-local helpers
  // ---------------------------------------------------------------------------
  logic [HK_W-1:0]  eff_hooks;
  logic [CNT_W-1:0] cur_max;
  logic             first_vld, next_vld;
  logic [CLS_W-1:0] first_cls, next_cls;

  // Hooks requested this frame: 0 still draws one hook, excess clamps.
  always_comb begin
    if (hooks_active == '0) begin
      eff_hooks = HK_W'(1);
    end else if (hooks_active > HK_W'(NUM_HOOKS)) begin
      eff_hooks = HK_W'(NUM_HOOKS);
    end else begin
      eff_hooks = hooks_active;
    end
  end

  // Object count of the class currently being walked.
  always_comb begin
    cur_max = '0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      if (cls_q == CLS_W'(c)) cur_max = max_q[c*CNT_W +: CNT_W];
    end
  end

  // Lowest non-empty class overall and lowest non-empty class after cls_q,
  // so empty classes are skipped without spending a cycle.
  always_comb begin
    first_vld = 1'b0;
    first_cls = '0;
    next_vld  = 1'b0;
    next_cls  = '0;
    for (int c = int'(NUM_CLASSES) - 1; c >= 0; c--) begin
      if (max_q[c*CNT_W +: CNT_W] != '0) begin
        first_vld = 1'b1;
        first_cls = CLS_W'(c);
        if (c > int'(cls_q)) begin
          next_vld = 1'b1;
          next_cls = CLS_W'(c);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counters and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cls_d         = cls_q;
    idx_d         = idx_q;
    hook_d        = hook_q;
    max_d         = max_q;
    hooks_d       = hooks_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    draw_req      = 1'b0;
    kind_c        = KIND_SPLASH;
    draw_cls      = '0;
    draw_idx      = '0;
    enable_random = 1'b0;
    timer_enable  = 1'b0;
    time_resetn   = 1'b1;
    rope_resetn   = 1'b1;
    obj_resetn    = 1'b1;
    level_up      = 1'b0;
    level_resetn  = 1'b1;

    // A tick while this frame is still being drawn is an overrun.
    if (tick_w && is_frame_draw(state_q)) begin
      pending_d = 1'b1;
      overrun_d = sat_inc(overrun_q);
    end

    unique case (state_q)
      ST_START: begin
        state_d = ST_SPLASH;
      end

      ST_SPLASH: begin
        draw_req    = 1'b1;
        kind_c      = KIND_SPLASH;
        rope_resetn = 1'b0;
        if (draw_done) state_d = ST_ARM;
      end

      ST_ARM: begin
        enable_random = 1'b1;
        time_resetn   = 1'b0;
        rope_resetn   = 1'b0;
        if (go) begin
          state_d   = ST_BG;
          pending_d = 1'b0;
          max_d     = max_count;
          hooks_d   = eff_hooks;
        end
      end

      ST_BG: begin
        draw_req     = 1'b1;
        kind_c       = KIND_BG;
        timer_enable = 1'b1;
        if (draw_done) begin
          if (first_vld) begin
            state_d = ST_OBJ;
            cls_d   = first_cls;
            idx_d   = '0;
          end else begin
            state_d = ST_HOOK;
            hook_d  = '0;
          end
        end
      end

      ST_OBJ: begin
        draw_req     = 1'b1;
        kind_c       = KIND_OBJ;
        draw_cls     = cls_q;
        draw_idx     = idx_q;
        timer_enable = 1'b1;
        if (draw_done) begin
          if (idx_q == cur_max - 1'b1) begin
            idx_d = '0;
            if (next_vld) begin
              cls_d = next_cls;
            end else begin
              state_d = ST_HOOK;
              hook_d  = '0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_HOOK: begin
        draw_req     = 1'b1;
        kind_c       = KIND_HOOK;
        draw_cls     = CLS_W'(hook_q);
        timer_enable = 1'b1;
        if (draw_done) begin
          if (hook_q == hooks_q - 1'b1) state_d = ST_NUM;
          else                          hook_d  = hook_q + 1'b1;
        end
      end

      ST_NUM: begin
        draw_req     = 1'b1;
        kind_c       = KIND_NUM;
        timer_enable = 1'b1;
        if (draw_done) state_d = ST_GAME;
      end

      ST_GAME: begin
        obj_resetn   = 1'b0;
        timer_enable = 1'b1;
        // Round end wins over a frame tick arriving in the same cycle.
        if (game_end) begin
          state_d = next_level ? ST_NEXT : ST_OVER;
        end else if (tick_w || pending_q) begin
          state_d   = ST_BG;
          pending_d = 1'b0;
          max_d     = max_count;
          hooks_d   = eff_hooks;
        end
      end

      ST_OVER: begin
        draw_req = 1'b1;
        kind_c   = KIND_OVER;
        if (draw_done) state_d = ST_DONE_OVER;
      end

      ST_DONE_OVER: begin
        time_resetn  = 1'b0;
        obj_resetn   = 1'b0;
        rope_resetn  = 1'b0;
        level_resetn = 1'b0;
        state_d      = go ? ST_WAIT_REL : ST_SPLASH;
      end

      // Game stays cleared until the key that dismissed the game-over screen
      // is released, so a held key cannot skip the splash.
      ST_WAIT_REL: begin
        time_resetn  = 1'b0;
        obj_resetn   = 1'b0;
        rope_resetn  = 1'b0;
        level_resetn = 1'b0;
        if (!go) state_d = ST_SPLASH;
      end

      ST_NEXT: begin
        draw_req = 1'b1;
        kind_c   = KIND_NEXT;
        if (draw_done) state_d = ST_DONE_NEXT;
      end

      ST_DONE_NEXT: begin
        time_resetn = 1'b0;
        obj_resetn  = 1'b0;
        rope_resetn = 1'b0;
        if (go) state_d = ST_LEVEL_UP;
      end

      ST_LEVEL_UP: begin
        level_up  = 1'b1;
        state_d   = ST_BG;
        pending_d = 1'b0;
        max_d     = max_count;
        hooks_d   = eff_hooks;
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign draw_kind   = kind_c;
  assign overrun_cnt = overrun_q;

  // State and counter registers; reset aborts any request on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_START;
      cls_q     <= '0;
      idx_q     <= '0;
      hook_q    <= '0;
      max_q     <= '0;
      hooks_q   <= HK_W'(1);
      pending_q <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      idx_q     <= idx_d;
      hook_q    <= hook_d;
      max_q     <= max_d;
      hooks_q   <= hooks_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
